// File: rtl/fpu_issue_queue.sv
// In-order FP reservation station: captures pending operands from the CDB, dispatches oldest entry first.
// Dispatch one cycle after push/capture; issue_ready_o drops when full (no bypass); eu_* held while eu_ready_i=0.
module fpu_issue_queue #(
  parameter int DEPTH       = 4,
  parameter int EU_CTL_LEN  = 4,
  parameter int FRM_LEN     = 3,
  parameter int ROB_IDX_LEN = 4,
  parameter int FLEN        = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic [EU_CTL_LEN-1:0]             issue_ctl_i,
  input  logic [FRM_LEN-1:0]                issue_rm_i,
  input  logic [ROB_IDX_LEN-1:0]            issue_rob_idx_i,
  input  logic [2:0]                        issue_rs_ready_i,
  input  logic [2:0][ROB_IDX_LEN-1:0]       issue_rs_idx_i,
  input  logic [2:0][FLEN-1:0]              issue_rs_value_i,
  input  logic                              cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0]            cdb_rob_idx_i,
  input  logic [FLEN-1:0]                   cdb_value_i,
  output logic                              eu_valid_o,
  input  logic                              eu_ready_i,
  output logic [EU_CTL_LEN-1:0]             eu_ctl_o,
  output logic [FRM_LEN-1:0]                eu_rm_o,
  output logic [ROB_IDX_LEN-1:0]            eu_rob_idx_o,
  output logic [FLEN-1:0]                   eu_rs1_value_o,
  output logic [FLEN-1:0]                   eu_rs2_value_o,
  output logic [FLEN-1:0]                   eu_rs3_value_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                        valid;
    logic [EU_CTL_LEN-1:0]       ctl;
    logic [FRM_LEN-1:0]          rm;
    logic [ROB_IDX_LEN-1:0]      rob_idx;
    logic [2:0]                  rs_ready;
    logic [2:0][ROB_IDX_LEN-1:0] rs_idx;
    logic [2:0][FLEN-1:0]        rs_value;
  } entry_t;

  entry_t           q [DEPTH];
  entry_t           head_e;
  entry_t           new_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_e        = q[head];
  assign issue_ready_o = (count < CNT_W'(DEPTH));
  assign eu_valid_o    = head_e.valid && (&head_e.rs_ready);
  assign push          = issue_valid_i && issue_ready_o && !flush_i;
  assign pop           = eu_valid_o && eu_ready_i && !flush_i;

  // Data outputs are gated so stale contents of a popped slot never leak out.
  assign eu_ctl_o       = head_e.valid ? head_e.ctl         : '0;
  assign eu_rm_o        = head_e.valid ? head_e.rm          : '0;
  assign eu_rob_idx_o   = head_e.valid ? head_e.rob_idx     : '0;
  assign eu_rs1_value_o = head_e.valid ? head_e.rs_value[0] : '0;
  assign eu_rs2_value_o = head_e.valid ? head_e.rs_value[1] : '0;
  assign eu_rs3_value_o = head_e.valid ? head_e.rs_value[2] : '0;

  // Incoming entry picks up a same-cycle CDB result so it is not missed.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.ctl      = issue_ctl_i;
    new_entry.rm       = issue_rm_i;
    new_entry.rob_idx  = issue_rob_idx_i;
    new_entry.rs_ready = issue_rs_ready_i;
    new_entry.rs_idx   = issue_rs_idx_i;
    new_entry.rs_value = issue_rs_value_i;
    for (int k = 0; k < 3; k++) begin
      if (!issue_rs_ready_i[k] && cdb_valid_i && (issue_rs_idx_i[k] == cdb_rob_idx_i)) begin
        new_entry.rs_ready[k] = 1'b1;
        new_entry.rs_value[k] = cdb_value_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < 3; k++) begin
          if (q[i].valid && !q[i].rs_ready[k] && cdb_valid_i &&
              (q[i].rs_idx[k] == cdb_rob_idx_i)) begin
            q[i].rs_ready[k] <= 1'b1;
            q[i].rs_value[k] <= cdb_value_i;
          end
        end
      end
      // Push targets a free slot, so it never collides with the popped head or a capture.
      if (pop) begin
        q[head].valid <= 1'b0;
        head          <= ptr_inc(head);
      end
      if (push) begin
        q[tail] <= new_entry;
        tail    <= ptr_inc(tail);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
